// File: rtl/bitwise_pkg.sv
// Shared definitions for the sequential bitwise logic unit.
//   OP_*   : 3-bit opcodes understood by bitwise_slice / bitwise_logic_seq.
//   S_*    : state encoding of the top-level controller.
//   state_t: enum view of the state encoding, also used on the debug port.
package bitwise_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_ANDN = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_BUSY = S_BUSY,
        ST_DONE = S_DONE
    } state_t;

endpackage

// File: rtl/bitwise_logic_seq_if.sv
// Operand/result bundle of bitwise_logic_seq.
//   in_valid/in_ready : operation handshake (op, in0, in1 qualified by in_valid)
//   out_valid/out_ready: result handshake (out, zero qualified by out_valid)
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where valid and ready are both high. Once valid is raised the sender holds
// its payload stable until that edge; ready never depends combinationally on
// valid.
// master: producer/consumer side (drives operands, accepts results).
// slave : the logic unit.
interface bitwise_logic_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zero;

    modport master (
        output in_valid, op, in0, in1, out_ready,
        input  in_ready, out_valid, out, zero
    );

    modport slave (
        input  in_valid, op, in0, in1, out_ready,
        output in_ready, out_valid, out, zero
    );
endinterface

// File: rtl/bitwise_slice.sv
// Combinational SLICE-bit bitwise operator.
//   out : SLICE-bit result
//   in0 : operand A slice
//   in1 : operand B slice
//   op  : opcode (OP_* in bitwise_pkg)
module bitwise_slice
    import bitwise_pkg::*;
#(
    parameter int SLICE = 8
) (
    output logic [SLICE-1:0] out,
    input  logic [SLICE-1:0] in0,
    input  logic [SLICE-1:0] in1,
    input  logic [2:0]       op
);

    always_comb begin
        out = in0 & in1;
        case (op)
            OP_AND:  out = in0 & in1;
            OP_OR:   out = in0 | in1;
            OP_XOR:  out = in0 ^ in1;
            OP_NAND: out = ~(in0 & in1);
            OP_NOR:  out = ~(in0 | in1);
            OP_XNOR: out = ~(in0 ^ in1);
            OP_ANDN: out = in0 & ~in1;
            OP_PASS: out = in0;
            default: out = in0 & in1;
        endcase
    end

endmodule

// File: rtl/bitwise_logic_seq.sv
// Multi-cycle bitwise logic unit: computes one of 8 bitwise operations on
// WIDTH-bit operands, SLICE bits per cycle, LSB slice first.
//   clock     : rising-edge clock
//   reset_n   : asynchronous active-low reset
//   bus       : operand/result handshake bundle (slave side)
//   dbg_state : current controller state
// Accept at edge E, slices written at E+1..E+NSLICE, out_valid after E+NSLICE.
module bitwise_logic_seq
    import bitwise_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    bitwise_logic_seq_if.slave   bus,
    output state_t               dbg_state
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    if ((SLICE < 1) || (WIDTH % SLICE != 0)) begin : g_bad_cfg
        $error("bitwise_logic_seq: WIDTH must be a positive multiple of SLICE");
    end

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] out_q;
    logic             zero_q;

    logic [SLICE-1:0] a_s;
    logic [SLICE-1:0] b_s;
    logic [SLICE-1:0] r_s;
    logic [WIDTH-1:0] out_next;

    // Route the slice addressed by the counter to the shared operator.
    always_comb begin
        a_s = '0;
        b_s = '0;
        for (int k = 0; k < NSLICE; k++) begin
            if (cnt == CW'(k)) begin
                a_s = a_q[k*SLICE +: SLICE];
                b_s = b_q[k*SLICE +: SLICE];
            end
        end
    end

    bitwise_slice #(.SLICE(SLICE)) u_slice (
        .out (r_s),
        .in0 (a_s),
        .in1 (b_s),
        .op  (op_q)
    );

    // Result word with the current slice merged in; on the last slice this is
    // the final result, which is what the zero flag is computed from.
    always_comb begin
        out_next = out_q;
        for (int k = 0; k < NSLICE; k++) begin
            if (cnt == CW'(k)) begin
                out_next[k*SLICE +: SLICE] = r_s;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (bus.in_valid)  state_next = ST_BUSY;
            ST_BUSY: if (cnt == LAST)   state_next = ST_DONE;
            ST_DONE: if (bus.out_ready) state_next = ST_IDLE;
            default:                    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            out_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_q    <= bus.in0;
                        b_q    <= bus.in1;
                        op_q   <= bus.op;
                        out_q  <= '0;
                        zero_q <= 1'b0;
                        cnt    <= '0;
                    end
                end
                ST_BUSY: begin
                    out_q <= out_next;
                    if (cnt == LAST) begin
                        zero_q <= (out_next == '0);
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    // DONE: result and flag held until the consumer takes them.
                end
            endcase
        end
    end

    // Handshake outputs decode state only, so neither valid input nor
    // out_ready reaches them combinationally.
    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.out       = out_q;
    assign bus.zero      = zero_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_bitwise_logic_seq.sv
// Self-checking bench for bitwise_logic_seq: directed vector table, random
// operations against a whole-word reference model, backpressure, input
// isolation, back-to-back, mid-operation reset and two extra configurations.
module tb_bitwise_logic_seq;
    import bitwise_pkg::*;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    bitwise_logic_seq_if #(.WIDTH(32)) bus ();
    bitwise_logic_seq_if #(.WIDTH(16)) b16 ();
    bitwise_logic_seq_if #(.WIDTH(64)) b64 ();
    state_t st, st16, st64;

    bitwise_logic_seq #(.WIDTH(32), .SLICE(8)) dut (
        .clock (clock), .reset_n (reset_n), .bus (bus), .dbg_state (st)
    );
    bitwise_logic_seq #(.WIDTH(16), .SLICE(16)) dut16 (
        .clock (clock), .reset_n (reset_n), .bus (b16), .dbg_state (st16)
    );
    bitwise_logic_seq #(.WIDTH(64), .SLICE(4)) dut64 (
        .clock (clock), .reset_n (reset_n), .bus (b64), .dbg_state (st64)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic         zq[$];
    logic [W-1:0] last_exp = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Whole-word reference, masked to the configuration width.
    function automatic logic [63:0] ref_logic(input logic [2:0] op, input logic [63:0] a,
                                              input logic [63:0] b, input int width);
        logic [63:0] r;
        logic [63:0] mask;
        case (op)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = a ^ b;
            3'd3:    r = ~(a & b);
            3'd4:    r = ~(a | b);
            3'd5:    r = ~(a ^ b);
            3'd6:    r = a & ~b;
            default: r = a;
        endcase
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return r & mask;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic start_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] exp, input logic expz);
        bit acc;
        acc = 1'b0;
        @(negedge clock);
        bus.op = op;
        bus.in0 = a;
        bus.in1 = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.in_ready === 1'b1) begin
                @(posedge clock);
                acc = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check("accept", 64'(acc), 64'd1);
        #1 bus.in_valid = 1'b0;
        exp_q.push_back(exp);
        zq.push_back(expz);
    endtask

    // Called right after the accepting edge; counts edges until out_valid.
    task automatic wait_result(input bit scramble);
        int n;
        logic [W-1:0] e;
        logic ez;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            #1;
            if (scramble) begin
                bus.in0 = $urandom;
                bus.in1 = $urandom;
                bus.op = 3'($urandom_range(0, 7));
            end
            @(negedge clock);
            if (bus.out_valid === 1'b1) begin
                n = i;
                break;
            end
            if (i == 1) check("busy_in_ready", 64'(bus.in_ready), 64'd0);
        end
        check("latency", 64'(n), 64'd4);
        e  = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        ez = (zq.size() > 0) ? zq.pop_front() : 1'bx;
        last_exp = e;
        check("out", 64'(bus.out), 64'(e));
        check("zero", 64'(bus.zero), 64'(ez));
    endtask

    task automatic release_result(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            @(negedge clock);
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_out", 64'(bus.out), 64'(last_exp));
            check("hold_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1 bus.out_ready = 1'b0;
        @(negedge clock);
        check("release_valid", 64'(bus.out_valid), 64'd0);
        check("release_in_ready", 64'(bus.in_ready), 64'd1);
        check("release_out_kept", 64'(bus.out), 64'(last_exp));
    endtask

    task automatic run_p16(input logic [15:0] a, input logic [15:0] b);
        int n;
        logic [63:0] e;
        n = 0;
        e = ref_logic(OP_NOR, 64'(a), 64'(b), 16);
        @(negedge clock);
        check("p16_in_ready", 64'(b16.in_ready), 64'd1);
        b16.op = OP_NOR;
        b16.in0 = a;
        b16.in1 = b;
        b16.in_valid = 1'b1;
        @(posedge clock);
        #1 b16.in_valid = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (b16.out_valid === 1'b1) begin
                n = i;
                break;
            end
        end
        check("p16_latency", 64'(n), 64'd1);
        check("p16_out", 64'(b16.out), e);
        check("p16_zero", 64'(b16.zero), 64'(e == 64'd0));
        b16.out_ready = 1'b1;
        @(posedge clock);
        #1 b16.out_ready = 1'b0;
    endtask

    task automatic run_p64(input logic [63:0] a, input logic [63:0] b);
        int n;
        logic [63:0] e;
        n = 0;
        e = ref_logic(OP_NOR, a, b, 64);
        @(negedge clock);
        check("p64_in_ready", 64'(b64.in_ready), 64'd1);
        b64.op = OP_NOR;
        b64.in0 = a;
        b64.in1 = b;
        b64.in_valid = 1'b1;
        @(posedge clock);
        #1 b64.in_valid = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (b64.out_valid === 1'b1) begin
                n = i;
                break;
            end
        end
        check("p64_latency", 64'(n), 64'd16);
        check("p64_out", b64.out, e);
        check("p64_zero", 64'(b64.zero), 64'(e == 64'd0));
        b64.out_ready = 1'b1;
        @(posedge clock);
        #1 b64.out_ready = 1'b0;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_out;
        logic         exp_zero;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r;
        logic [2:0]  rop;
        logic [W-1:0] ra, rb;

        vecs[0] = '{OP_AND,  32'hF0F0_1234, 32'hFF00_FF00, 32'hF000_1200, 1'b0};
        vecs[1] = '{OP_OR,   32'h0F0F_0000, 32'h00F0_F0F0, 32'h0FFF_F0F0, 1'b0};
        vecs[2] = '{OP_XOR,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1};
        vecs[3] = '{OP_NAND, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[4] = '{OP_NOR,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
        vecs[5] = '{OP_XNOR, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0};
        vecs[6] = '{OP_ANDN, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0000, 1'b0};
        vecs[7] = '{OP_PASS, 32'hA5A5_A5A5, 32'h1234_5678, 32'hA5A5_A5A5, 1'b0};
        vecs[8] = '{OP_PASS, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[9] = '{OP_AND,  32'h8000_0001, 32'h0000_0001, 32'h0000_0001, 1'b0};

        bus.in_valid = 1'b1;
        bus.op = OP_AND;
        bus.in0 = 32'hFFFF_FFFF;
        bus.in1 = 32'hFFFF_FFFF;
        bus.out_ready = 1'b0;
        b16.in_valid = 1'b0; b16.op = '0; b16.in0 = '0; b16.in1 = '0; b16.out_ready = 1'b0;
        b64.in_valid = 1'b0; b64.op = '0; b64.in0 = '0; b64.in1 = '0; b64.out_ready = 1'b0;

        // Reset held with in_valid asserted.
        repeat (3) @(negedge clock);
        check("rst_out", 64'(bus.out), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_zero", 64'(bus.zero), 64'd0);
        check("rst_state", 64'(st), 64'(S_IDLE));
        reset_n = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clock);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_no_accept", 64'(bus.out_valid), 64'd0);

        // Directed table; the first entry also exercises backpressure and
        // operand changes while busy.
        foreach (vecs[i]) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_out, vecs[i].exp_zero);
            wait_result(i == 0);
            release_result((i == 0) ? 10 : 0);
        end

        // Back-to-back: release and present the next op at the same time.
        start_op(OP_XOR, 32'h0000_FFFF, 32'h00FF_00FF, 32'h00FF_FF00, 1'b0);
        wait_result(1'b0);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.op = OP_NAND;
        bus.in0 = 32'hFF00_FF00;
        bus.in1 = 32'hF0F0_F0F0;
        exp_q.push_back(32'h0FFF_0FFF);
        zq.push_back(1'b0);
        @(posedge clock);
        #1 bus.out_ready = 1'b0;
        @(negedge clock);
        check("b2b_idle_in_ready", 64'(bus.in_ready), 64'd1);
        check("b2b_idle_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clock);
        #1 bus.in_valid = 1'b0;
        wait_result(1'b0);
        release_result(0);

        // Reset two cycles into BUSY.
        start_op(OP_OR, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        check("midop_partial", 64'(bus.out), 64'h0000_FFFF);
        reset_n = 1'b0;
        #1;
        check("midop_rst_out", 64'(bus.out), 64'd0);
        check("midop_rst_valid", 64'(bus.out_valid), 64'd0);
        exp_q.delete();
        zq.delete();
        repeat (2) @(negedge clock);
        check("midop_rst_still_invalid", 64'(bus.out_valid), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("midop_in_ready", 64'(bus.in_ready), 64'd1);
        start_op(OP_ANDN, 32'h1357_9BDF, 32'h0F0F_0F0F, 32'h1050_90D0, 1'b0);
        wait_result(1'b0);
        release_result(0);

        // Random operations against the reference model.
        for (int i = 0; i < 200; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? ra : W'($urandom);
            if ($urandom_range(0, 15) == 0) ra = '0;
            r = ref_logic(rop, 64'(ra), 64'(rb), W);
            start_op(rop, ra, rb, r[W-1:0], r[W-1:0] == '0);
            wait_result(i[0]);
            release_result($urandom_range(0, 2));
        end

        // Other configurations, NOR.
        run_p16(16'h1234, 16'h0F0F);
        run_p16(16'hFFFF, 16'h0000);
        run_p64(64'h0123_4567_89AB_CDEF, 64'h00FF_00FF_0000_FFFF);
        run_p64(64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
